// File: rtl/alu_share_arb.sv
// Two-requester front end for a single shared ALU. Round-robin arbitration on
// contention, a one-entry registered response slot with valid/ready handshake,
// and a saturating counter of contended cycles.
module alu_share_arb #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag,

  output logic [15:0]      conflict_cnt
);

  logic             rr_ptr;
  logic             slot_free;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             conflict;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [2:0]       alu_op;
  logic [TAG_W-1:0] alu_tag;
  logic [31:0]      alu_y;

  // Grant decision: a grant only ever goes to a valid requester, so a grant is an accept.
  always_comb begin
    slot_free = !rsp_valid || rsp_ready;
    grant0    = !rst && slot_free && req0_valid && (!req1_valid || !rr_ptr);
    grant1    = !rst && slot_free && req1_valid && (!req0_valid ||  rr_ptr);
    accept    = grant0 || grant1;
    conflict  = !rst && slot_free && req0_valid && req1_valid;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Operand steering into the single shared ALU.
  always_comb begin
    alu_a   = grant1 ? req1_a   : req0_a;
    alu_b   = grant1 ? req1_b   : req0_b;
    alu_op  = grant1 ? req1_op  : req0_op;
    alu_tag = grant1 ? req1_tag : req0_tag;
  end

  // Shared ALU; ADD/SUB wrap modulo 2^32, unused opcodes yield zero.
  always_comb begin
    alu_y = 32'd0;
    case (alu_op)
      3'b000:  alu_y = alu_a + alu_b;
      3'b001:  alu_y = alu_a - alu_b;
      3'b010:  alu_y = alu_a & alu_b;
      3'b011:  alu_y = alu_a | alu_b;
      3'b100:  alu_y = alu_a ^ alu_b;
      3'b101:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = 32'd0;
    endcase
  end

  // Response slot: load on accept, drop valid when consumed, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= 32'd0;
      rsp_zero   <= 1'b0;
      rsp_src    <= 1'b0;
      rsp_tag    <= '0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_y;
      rsp_zero   <= (alu_y == 32'd0);
      rsp_src    <= grant1;
      rsp_tag    <= alu_tag;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  // Round-robin pointer: after a grant, the other requester gets priority next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (grant0) begin
      rr_ptr <= 1'b1;
    end else if (grant1) begin
      rr_ptr <= 1'b0;
    end
  end

  // Saturating count of cycles in which both requesters competed for a free slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= 16'd0;
    end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: vector table for the ALU path, then
// hand-written sequences for contention, backpressure, reset and saturation.
module tb_alu_share_arb;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [3:0]  req0_tag, req1_tag;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_src;
  logic [3:0]  rsp_tag;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  alu_share_arb #(.TAG_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_op      (req0_op),
    .req0_tag     (req0_tag),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_op      (req1_op),
    .req1_tag     (req1_tag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_src      (rsp_src),
    .rsp_tag      (rsp_tag),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd5,          32'd3,          3'b001, 4'd2,  32'd2};
    vecs[1]  = '{1'b1, 32'hFFFFFFFF,   32'd1,          3'b000, 4'd3,  32'd0};
    vecs[2]  = '{1'b0, 32'h80000000,   32'd1,          3'b101, 4'd4,  32'd1};
    vecs[3]  = '{1'b1, 32'd7,          32'd9,          3'b111, 4'd5,  32'd0};
    vecs[4]  = '{1'b0, 32'hF0F0F0F0,   32'h0FF00FF0,   3'b010, 4'd6,  32'h00F000F0};
    vecs[5]  = '{1'b1, 32'hF0F0F0F0,   32'h0FF00FF0,   3'b011, 4'd7,  32'hFFF0FFF0};
    vecs[6]  = '{1'b0, 32'hF0F0F0F0,   32'h0FF00FF0,   3'b100, 4'd8,  32'hFF00FF00};
    vecs[7]  = '{1'b1, 32'd3,          32'd5,          3'b001, 4'd9,  32'hFFFFFFFE};
    vecs[8]  = '{1'b0, 32'd1,          32'h80000000,   3'b101, 4'd10, 32'd0};
    vecs[9]  = '{1'b1, 32'hFFFFFFFF,   32'd0,          3'b101, 4'd11, 32'd1};
    vecs[10] = '{1'b0, 32'd5,          32'd5,          3'b110, 4'd12, 32'd0};

    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0; req0_tag = '0;
    req1_a = '0; req1_b = '0; req1_op = '0; req1_tag = '0;
    rsp_ready = 1'b1;

    // Reset state, with a requester already valid.
    #12;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_rsp_zero", rsp_zero, 0);
    chk("reset_rsp_src", rsp_src, 0);
    chk("reset_rsp_tag", rsp_tag, 0);
    chk("reset_conflict", conflict_cnt, 0);
    chk("reset_req0_ready", req0_ready, 0);
    req0_valid = 1'b0;
    rst = 1'b0;

    // Table-driven single operations, one requester at a time.
    for (int i = 0; i < 11; i++) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (vecs[i].src == 1'b0) begin
        req0_valid = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b;
        req0_op = vecs[i].op; req0_tag = vecs[i].tag;
      end else begin
        req1_valid = 1'b1; req1_a = vecs[i].a; req1_b = vecs[i].b;
        req1_op = vecs[i].op; req1_tag = vecs[i].tag;
      end
      #1;
      chk($sformatf("vec%0d_req0_ready", i), req0_ready, vecs[i].src == 1'b0);
      chk($sformatf("vec%0d_req1_ready", i), req1_ready, vecs[i].src == 1'b1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, 1);
      chk($sformatf("vec%0d_result", i), rsp_result, vecs[i].res);
      chk($sformatf("vec%0d_zero", i), rsp_zero, vecs[i].res == 32'd0);
      chk($sformatf("vec%0d_src", i), rsp_src, vecs[i].src);
      chk($sformatf("vec%0d_tag", i), rsp_tag, vecs[i].tag);
    end
    chk("single_no_conflict", conflict_cnt, 0);

    // Consumed response with nothing new: valid drops.
    step();
    chk("drain_rsp_valid", rsp_valid, 0);

    // Contention from a fresh reset: grants alternate starting with requester 0.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req0_a = 32'd10;  req0_b = 32'd20; req0_op = 3'b000; req0_tag = 4'd1;
    req1_a = 32'd100; req1_b = 32'd1;  req1_op = 3'b001; req1_tag = 4'd9;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont%0d_req0_ready", i), req0_ready, (i % 2) == 0);
      chk($sformatf("cont%0d_req1_ready", i), req1_ready, (i % 2) == 1);
      @(posedge clk);
      #1;
      chk($sformatf("cont%0d_src", i), rsp_src, (i % 2) == 1);
      chk($sformatf("cont%0d_result", i), rsp_result, ((i % 2) == 0) ? 32'd30 : 32'd99);
      chk($sformatf("cont%0d_tag", i), rsp_tag, ((i % 2) == 0) ? 32'd1 : 32'd9);
      chk($sformatf("cont%0d_conflict", i), conflict_cnt, i + 1);
    end

    // Backpressure: slot full, nothing granted, response and counter frozen.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d_req0_ready", i), req0_ready, 0);
      chk($sformatf("bp%0d_req1_ready", i), req1_ready, 0);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_rsp_valid", i), rsp_valid, 1);
      chk($sformatf("bp%0d_result", i), rsp_result, 32'd99);
      chk($sformatf("bp%0d_src", i), rsp_src, 1);
      chk($sformatf("bp%0d_tag", i), rsp_tag, 9);
      chk($sformatf("bp%0d_conflict", i), conflict_cnt, 4);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_req0_ready", req0_ready, 1);
    chk("bp_release_req1_ready", req1_ready, 0);
    step();
    chk("bp_release_rsp_valid", rsp_valid, 1);
    chk("bp_release_src", rsp_src, 0);
    chk("bp_release_result", rsp_result, 32'd30);
    chk("bp_release_conflict", conflict_cnt, 5);

    // Asynchronous reset with a response pending.
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_result", rsp_result, 0);
    chk("arst_rsp_tag", rsp_tag, 0);
    chk("arst_conflict", conflict_cnt, 0);
    chk("arst_req0_ready", req0_ready, 0);
    chk("arst_req1_ready", req1_ready, 0);
    rst = 1'b0;
    req0_valid = 1'b0;
    #1;
    chk("post_rst_req1_ready", req1_ready, 1);
    step();
    chk("post_rst_src1", rsp_src, 1);
    chk("post_rst_result1", rsp_result, 32'd99);
    req0_valid = 1'b1;
    #1;
    chk("post_rst_req0_prio", req0_ready, 1);
    chk("post_rst_req1_wait", req1_ready, 0);
    step();
    chk("post_rst_src0", rsp_src, 0);
    chk("post_rst_result0", rsp_result, 32'd30);
    chk("post_rst_conflict", conflict_cnt, 1);

    // Saturation: keep both requesters contending well past 0xFFFF cycles.
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_conflict", conflict_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
